// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
//   Round-robin arbiter that shares one port of the dual-port block RAM between
//   NUM_REQ requesters. Each cycle, one granted access is registered onto the RAM port.
//   Read data returns to the issuing requester two cycles after its ack.
//
//   Optional feature: define DPRAM_ARB_CLEAR_EN to sweep CLEAR_VALUE into every RAM
//   word after reset. Arbitration starts once the sweep is complete.
//
// Ports
//   i_clock        single clock, also clocks the RAM port
//   i_reset        synchronous, active-high
//   i_req/i_we     per-requester request and write-enable (we qualified by req)
//   i_addr/i_wdata flattened operands, requester i at [i*W +: W]
//   o_ack          one-hot pulse, request accepted
//   o_rvalid       one-hot pulse, o_rdata holds that requester's read result
//   o_rdata        shared read data
//   o_busy         high while the clear sweep runs
//   o_ram_*        registered RAM port controls; i_ram_q is the RAM read data
module dpram_port_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned ADDRWIDTH   = 8,
    parameter int unsigned DATAWIDTH   = 8,
    parameter int unsigned CLEAR_VALUE = 0
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ-1:0]           i_we,
    input  logic [NUM_REQ*ADDRWIDTH-1:0] i_addr,
    input  logic [NUM_REQ*DATAWIDTH-1:0] i_wdata,
    output logic [NUM_REQ-1:0]           o_ack,
    output logic [NUM_REQ-1:0]           o_rvalid,
    output logic [DATAWIDTH-1:0]         o_rdata,
    output logic                         o_busy,
    output logic [ADDRWIDTH-1:0]         o_ram_address,
    output logic [DATAWIDTH-1:0]         o_ram_data,
    output logic                         o_ram_wren,
    input  logic [DATAWIDTH-1:0]         i_ram_q
);

    localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDXW-1:0] LAST_RESET = IDXW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [IDXW-1:0]      r_last;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   r_rvalid;
    logic [DATAWIDTH-1:0] r_rdata;
    logic [ADDRWIDTH-1:0] r_ram_address;
    logic [DATAWIDTH-1:0] r_ram_data;
    logic                 r_ram_wren;

    // Read tags: stage 1 tracks the access on the RAM port, stage 2 the RAM output.
    logic                 r_tag1_vld;
    logic [IDXW-1:0]      r_tag1_idx;
    logic                 r_tag2_vld;
    logic [IDXW-1:0]      r_tag2_idx;

    logic                 w_grant;
    logic [IDXW-1:0]      w_winner;
    logic [IDXW-1:0]      w_scan;
    logic [ADDRWIDTH-1:0] w_sel_addr;
    logic [DATAWIDTH-1:0] w_sel_wdata;
    logic                 w_sel_we;
    logic                 w_clearing;
    logic [ADDRWIDTH-1:0] w_clr_addr;
    logic [DATAWIDTH-1:0] w_clr_data;

    assign w_clr_data = DATAWIDTH'(CLEAR_VALUE);

`ifdef DPRAM_ARB_CLEAR_EN
    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [ADDRWIDTH-1:0] r_clr_cnt;
    logic [ADDRWIDTH-1:0] w_clr_cnt_next;
    logic                 r_busy;
    logic                 w_busy_next;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= StClear;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
            r_busy    <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_busy_next    = r_busy;
        case (r_state)
            StClear: begin
                w_clr_cnt_next = r_clr_cnt + ADDRWIDTH'(1);
                // The edge that registers the last word ends the sweep.
                if (r_clr_cnt == {ADDRWIDTH{1'b1}}) begin
                    w_state_next = StRun;
                    w_busy_next  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign w_clearing = (r_state == StClear);
    assign w_clr_addr = r_clr_cnt;
    assign o_busy     = r_busy;
`else
    assign w_clearing = 1'b0;
    assign w_clr_addr = '0;
    assign o_busy     = 1'b0;
`endif

    // Round-robin scan starting just after the last winner, wrapping to 0.
    always_comb begin
        w_grant  = 1'b0;
        w_winner = r_last;
        w_scan   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_scan = IDXW'((32'(r_last) + k) % NUM_REQ);
            if (!w_grant && i_req[w_scan]) begin
                w_grant  = 1'b1;
                w_winner = w_scan;
            end
        end
    end

    assign w_sel_addr  = i_addr[32'(w_winner)*ADDRWIDTH +: ADDRWIDTH];
    assign w_sel_wdata = i_wdata[32'(w_winner)*DATAWIDTH +: DATAWIDTH];
    assign w_sel_we    = i_we[w_winner];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last        <= LAST_RESET;
            r_ack         <= '0;
            r_rvalid      <= '0;
            r_rdata       <= '0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_wren    <= 1'b0;
            r_tag1_vld    <= 1'b0;
            r_tag1_idx    <= '0;
            r_tag2_vld    <= 1'b0;
            r_tag2_idx    <= '0;
        end else begin
            r_tag2_vld <= r_tag1_vld;
            r_tag2_idx <= r_tag1_idx;
            r_rvalid   <= '0;
            if (r_tag2_vld) begin
                r_rvalid <= ONE_HOT0 << r_tag2_idx;
                r_rdata  <= i_ram_q;
            end

            if (w_clearing) begin
                // Requests stay pending at the inputs; nothing is acked during the sweep.
                r_ack         <= '0;
                r_ram_address <= w_clr_addr;
                r_ram_data    <= w_clr_data;
                r_ram_wren    <= 1'b1;
                r_tag1_vld    <= 1'b0;
            end else if (w_grant) begin
                r_ack         <= ONE_HOT0 << w_winner;
                r_ram_address <= w_sel_addr;
                r_ram_data    <= w_sel_wdata;
                r_ram_wren    <= w_sel_we;
                r_tag1_vld    <= ~w_sel_we;
                r_tag1_idx    <= w_winner;
                r_last        <= w_winner;
            end else begin
                r_ack      <= '0;
                r_ram_wren <= 1'b0;
                r_tag1_vld <= 1'b0;
            end
        end
    end

    assign o_ack         = r_ack;
    assign o_rvalid      = r_rvalid;
    assign o_rdata       = r_rdata;
    assign o_ram_address = r_ram_address;
    assign o_ram_data    = r_ram_data;
    assign o_ram_wren    = r_ram_wren;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
module tb_dpram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NW = 1 << AW;
`ifdef DPRAM_ARB_CLEAR_EN
    localparam int unsigned CLR_VAL = 'h5A;
    localparam logic RST_BUSY = 1'b1;
    localparam logic [AW-1:0] ADDR_AFTER_RESET = AW'(NW - 1);
`else
    localparam int unsigned CLR_VAL = 0;
    localparam logic RST_BUSY = 1'b0;
    localparam logic [AW-1:0] ADDR_AFTER_RESET = '0;
`endif

    logic                i_clock = 1'b0;
    logic                i_reset = 1'b1;
    logic [N-1:0]        i_req = '0;
    logic [N-1:0]        i_we = '0;
    logic [N*AW-1:0]     i_addr = '0;
    logic [N*DW-1:0]     i_wdata = '0;
    logic [N-1:0]        o_ack;
    logic [N-1:0]        o_rvalid;
    logic [DW-1:0]       o_rdata;
    logic                o_busy;
    logic [AW-1:0]       o_ram_address;
    logic [DW-1:0]       o_ram_data;
    logic                o_ram_wren;
    logic [DW-1:0]       ram_q;

    dpram_port_arbiter #(
        .NUM_REQ    (N),
        .ADDRWIDTH  (AW),
        .DATAWIDTH  (DW),
        .CLEAR_VALUE(CLR_VAL)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_ack        (o_ack),
        .o_rvalid     (o_rvalid),
        .o_rdata      (o_rdata),
        .o_busy       (o_busy),
        .o_ram_address(o_ram_address),
        .o_ram_data   (o_ram_data),
        .o_ram_wren   (o_ram_wren),
        .i_ram_q      (ram_q)
    );

    always #5 i_clock = ~i_clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(a * 37 + 11);
    endfunction

    // Backdoor ops, each active for exactly one posedge: 1 fill pattern, 2 single write,
    // 3 shadow-only fill with the clear value.
    int            bd_op = 0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_val = '0;

    // Environment RAM (one port of the dpram).
    logic [DW-1:0] ram_mem [NW];
    always @(posedge i_clock) begin
        if (bd_op == 1) begin
            for (int a = 0; a < NW; a++) ram_mem[a] <= pat(a);
        end else if (bd_op == 2) begin
            ram_mem[bd_addr] <= bd_val;
        end else if (o_ram_wren) begin
            ram_mem[o_ram_address] <= o_ram_data;
        end
        ram_q <= ram_mem[o_ram_address];
    end

    // Reference model: serialised accesses against a shadow memory; a read returns
    // the memory contents at its grant, delivered two edges later.
    typedef struct {
        int unsigned   due;
        int            idx;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    logic [DW-1:0] shadow [NW];
    logic          model_en = 1'b0;
    logic          m_valid = 1'b0;
    int unsigned   cyc = 0;
    int            m_last = N - 1;
    logic [N-1:0]  m_ack = '0;
    logic [N-1:0]  m_rv = '0;
    logic [DW-1:0] m_rd = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_wren = 1'b0;

    always @(posedge i_clock) begin
        int            w;
        logic [AW-1:0] a;
        cyc++;
        if (bd_op == 1) for (int k = 0; k < NW; k++) shadow[k] = pat(k);
        if (bd_op == 2) shadow[bd_addr] = bd_val;
        if (bd_op == 3) for (int k = 0; k < NW; k++) shadow[k] = DW'(CLR_VAL);
        m_rv  = '0;
        m_ack = '0;
        if (!model_en || i_reset) begin
            m_last  = N - 1;
            pend.delete();
            m_wren  = 1'b0;
            m_addr  = ADDR_AFTER_RESET;
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b1;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                m_rv[pend[0].idx] = 1'b1;
                m_rd = pend[0].data;
                void'(pend.pop_front());
            end
            w = -1;
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && i_req[(m_last + k) % N]) w = (m_last + k) % N;
            end
            m_wren = 1'b0;
            if (w >= 0) begin
                m_ack[w] = 1'b1;
                m_last   = w;
                a        = i_addr[w*AW +: AW];
                m_addr   = a;
                if (i_we[w]) begin
                    m_wren    = 1'b1;
                    m_data    = i_wdata[w*DW +: DW];
                    shadow[a] = m_data;
                end else begin
                    pend.push_back('{due: cyc + 2, idx: w, data: shadow[a]});
                end
            end
        end
    end

    always @(negedge i_clock) begin
        if (m_valid && model_en) begin
            check("ack", 32'(o_ack), 32'(m_ack));
            check("rvalid", 32'(o_rvalid), 32'(m_rv));
            check("ram_wren", 32'(o_ram_wren), 32'(m_wren));
            check("ram_address", 32'(o_ram_address), 32'(m_addr));
            check("busy", 32'(o_busy), 32'(0));
            if (m_wren) check("ram_data", 32'(o_ram_data), 32'(m_data));
            if (m_rv != 0) check("rdata", 32'(o_rdata), 32'(m_rd));
        end
    end

    // Requester-side stimulus state.
    logic [N-1:0]  d_req = '0;
    logic [N-1:0]  d_we = '0;
    logic [AW-1:0] d_addr [N];
    logic [DW-1:0] d_wdata [N];

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            i_addr[i*AW +: AW]  = d_addr[i];
            i_wdata[i*DW +: DW] = d_wdata[i];
        end
        i_req = d_req;
        i_we  = d_we;
    endtask

    task automatic tick();
        @(negedge i_clock);
        bd_op = 0;
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v == (N'(1) << i)) r = i;
        return r;
    endfunction

    task automatic do_reset();
        int n;
        int bad;
        model_en = 1'b0;
        i_reset  = 1'b1;
        bd_op    = 1;
        tick();
        tick();
        check("rst_ack", 32'(o_ack), 32'(0));
        check("rst_rvalid", 32'(o_rvalid), 32'(0));
        check("rst_rdata", 32'(o_rdata), 32'(0));
        check("rst_wren", 32'(o_ram_wren), 32'(0));
        check("rst_address", 32'(o_ram_address), 32'(0));
        check("rst_data", 32'(o_ram_data), 32'(0));
        check("rst_busy", 32'(o_busy), 32'(RST_BUSY));
        i_reset = 1'b0;
`ifdef DPRAM_ARB_CLEAR_EN
        n   = 0;
        bad = 0;
        while (o_busy && n < 2 * NW) begin
            if (o_ack != 0) bad++;
            n++;
            tick();
        end
        check("busy_cycles", 32'(n), 32'(NW));
        check("ack_in_clear", 32'(bad), 32'(0));
        // Last word is still on the port; everything below it is already in the RAM.
        bad = 0;
        for (int a = 0; a < NW - 1; a++) if (ram_mem[a] !== DW'(CLR_VAL)) bad++;
        check("clear_fill", 32'(bad), 32'(0));
        check("clear_last", {15'd0, o_ram_wren, 8'(o_ram_address), 8'(o_ram_data)},
              {15'd0, 1'b1, 8'(NW - 1), 8'(CLR_VAL)});
        bd_op    = 3;
        model_en = 1'b1;
`else
        n   = 0;
        bad = 0;
        model_en = 1'b1;
`endif
    endtask

    task automatic drain();
        int n = 0;
        d_req = d_req & ~o_ack;
        drive();
        while (d_req != 0 && n < 50) begin
            tick();
            d_req = d_req & ~o_ack;
            drive();
            n++;
        end
        check("drain", 32'(d_req), 32'(0));
        repeat (3) tick();
    endtask

    int exp_seq [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        int ack_seq [8];
        int rv_seq [8];
        for (int i = 0; i < N; i++) begin
            d_addr[i]  = '0;
            d_wdata[i] = '0;
        end

        // Requester 0 holds a read from reset; it must win the first arbitration.
        d_req = 3'b001;
        drive();
        do_reset();
        tick();
        check("first_ack", 32'(o_ack), 32'(3'b001));
        d_req = '0;
        drive();
        repeat (3) tick();

        // mem[0x12] = 0xA5, single read by requester 1.
        bd_op = 2; bd_addr = 8'h12; bd_val = 8'hA5;
        tick();
        d_req = 3'b010; d_we = '0; d_addr[1] = 8'h12;
        drive();
        tick();
        check("t1_ack", 32'(o_ack), 32'(3'b010));
        d_req = '0;
        drive();
        tick();
        check("t1_rvalid_early", 32'(o_rvalid), 32'(0));
        tick();
        check("t1_rvalid", 32'(o_rvalid), 32'(3'b010));
        check("t1_rdata", 32'(o_rdata), 32'(8'hA5));

        // Idle for 10 cycles.
        for (int t = 0; t < 10; t++) begin
            tick();
            check("idle", {29'd0, o_ram_wren, 1'b0, |{o_ack, o_rvalid}}, 32'(0));
        end

        // Write then read-after-write from another requester.
        d_req = 3'b001; d_we = 3'b001; d_addr[0] = 8'h40; d_wdata[0] = 8'h3C;
        drive();
        tick();
        check("t3_wack", 32'(o_ack), 32'(3'b001));
        d_req = 3'b100; d_we = '0; d_addr[2] = 8'h40;
        drive();
        tick();
        check("t3_rack", 32'(o_ack), 32'(3'b100));
        d_req = '0;
        drive();
        tick();
        tick();
        check("t3_rvalid", 32'(o_rvalid), 32'(3'b100));
        check("t3_rdata", 32'(o_rdata), 32'(8'h3C));

        // All three requesters reading back-to-back from a fresh pointer.
        do_reset();
        d_we = '0;
        for (int i = 0; i < N; i++) d_addr[i] = AW'($urandom_range(0, 15));
        d_req = '1;
        drive();
        for (int t = 0; t < 8; t++) begin
            tick();
            ack_seq[t] = oh_idx(o_ack);
            rv_seq[t]  = oh_idx(o_rvalid);
            for (int i = 0; i < N; i++) begin
                if (o_ack[i]) begin
                    if (t >= 3) d_req[i] = 1'b0;
                    d_addr[i] = AW'($urandom_range(0, 15));
                end
            end
            drive();
        end
        for (int t = 0; t < 6; t++) begin
            check("t2_ack_seq", 32'(ack_seq[t]), 32'(exp_seq[t]));
            check("t2_rv_seq", 32'(rv_seq[t + 2]), 32'(exp_seq[t]));
        end
        repeat (2) tick();

        // Randomised traffic, small address window to provoke read-after-write.
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (d_req[i] && o_ack[i]) d_req[i] = 1'b0;
                if (!d_req[i] && $urandom_range(0, 3) != 0) begin
                    d_req[i]   = 1'b1;
                    d_we[i]    = 1'($urandom_range(0, 1));
                    d_addr[i]  = AW'($urandom_range(0, 15));
                    d_wdata[i] = DW'($urandom);
                end
            end
            drive();
            tick();
        end
        drain();

        // Reset one cycle after a read ack: the read must never return.
        d_req = 3'b010; d_we = '0; d_addr[1] = 8'h05;
        drive();
        tick();
        check("t4_ack", 32'(o_ack), 32'(3'b010));
        d_req = '0;
        drive();
        do_reset();
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
